mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//   Parametrised successor of the pipeline memory stage: drives a request/acknowledge data-memory
//   port, so cache misses stall the pipeline for a variable number of cycles. Supports RV32I
//   byte/half/word loads (sign/zero-extended) and stores (byte enables). Contains the M->W register.
//   Sits between the execute-stage M register and writeback; StallM goes to the hazard unit.
// PARAMETERS
//   XLEN      32  data/address width (multiple of 8; byte lanes = XLEN/8)
//   RS_W      2   width of ResultSrc field carried to writeback
//   REG_AW    5   register-file address width (RdM/RdW)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   RegWriteM    in   1        instruction in M writes rd
//   ResultSrcM   in   RS_W     writeback mux select, passed through
//   MemReadM     in   1        load in M
//   MemWriteM    in   1        store in M
//   MemSizeM     in   3        funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM   in   XLEN     effective address / ALU result
//   WriteDataM   in   XLEN     store data (rs2), right-aligned
//   RdM          in   REG_AW   destination register
//   StallM       out  1        hold F/D/E/M registers this cycle
//   mem_req      out  1        memory request valid
//   mem_we       out  1        request is a write
//   mem_addr     out  XLEN     word-aligned address (low log2(XLEN/8) bits zero)
//   mem_wdata    out  XLEN     store data replicated onto lanes
//   mem_be       out  XLEN/8   byte enables (writes); all ones for reads
//   mem_rdata    in   XLEN     read data, valid when mem_ack
//   mem_ack      in   1        request completes this cycle (may be same cycle as mem_req)
//   RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW   out   W-stage register contents
//   MisalignW    out  1        misaligned access flagged (see CONFIGURATION)
// BEHAVIOUR
//   - FSM {IDLE, WAIT}. Reset: state IDLE; all W outputs 0; mem_req=0 while rst=1.
//   - IDLE: access = MemReadM|MemWriteM. If access, mem_req=1 combinationally.
//     ack same cycle -> no stall; W register captures at next edge (zero-wait hit).
//     no ack -> StallM=1, go WAIT.
//   - WAIT: mem_req held with identical addr/we/wdata/be (M inputs frozen by StallM);
//     StallM=1 until the cycle mem_ack=1; that cycle StallM=0, W captures, -> IDLE.
//   - While StallM=1 the W register loads a bubble: RegWriteW=0, MisalignW=0, other fields don't-care.
//   - Non-memory instruction: passes through in one cycle, no request, ReadDataW=0.
//   - Load extract: lane = ALUResultM[1:0] (XLEN=32); B/BU take byte lane, H/HU take half at
//     addr[1]; signed forms sign-extend to XLEN, U forms zero-extend; W passes word.
//   - Store: B -> data[7:0] on every lane, be = 1<<addr[1:0]; H -> data[15:0] on both halves,
//     be = 0011<<addr[1]*2; W -> be=1111.
//   - Reset mid-WAIT: returns to IDLE, request dropped, StallM=0; late ack is ignored.
//   - mem_ack while mem_req=0 is ignored.
// CONFIGURATION
//   MEM_MISALIGN_TRAP_EN defined: H at addr[0]=1 or W at addr[1:0]!=0 issues no request,
//     no stall; W register gets RegWriteW=0, MisalignW=1 for that instruction.
//   Not defined: low address bits below access size are ignored (forced to 0) and the
//     access proceeds; MisalignW tied 0.
// STRUCTURE
//   mem_stage_pkg: mem_size_e enum (funct3 encodings), state_e {IDLE,WAIT}, lane-count const.
//   Sub-module mem_lane_align: combinational store replicate/byte-enable and load
//   extract/extend; FSM and W register stay in mem_stage_hs.
// TESTING
//   1 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> StallM never 1; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
//   2 LB addr 0x103, ack after 3 cycles, rdata 0x80000000 -> StallM=1 for 3 cycles, 3 bubbles, then ReadDataW=0xFFFFFF80;
//     LBU same -> 0x00000080.
//   3 SH addr 0x102, data 0x1234ABCD -> mem_we=1, mem_addr=0x100, mem_be=1100, mem_wdata=0xABCDABCD.
//   4 rst asserted in WAIT, ack arrives 1 cycle later -> mem_req=0, StallM=0, all W outputs 0, ack ignored.
//   5 LW addr 0x102 with MEM_MISALIGN_TRAP_EN -> no mem_req, MisalignW=1, RegWriteW=0;
//     without -> mem_addr=0x100, normal load.
//   6 back-to-back ADD, SW(hit), LW(2-cycle miss) -> ADD and SW in W on consecutive cycles, LW after 2 bubbles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the handshaked memory stage: funct3 access sizes, FSM states, lane count.
package mem_stage_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int LANES_DEFAULT = XLEN_DEFAULT / 8;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte enables, load extraction and extension.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   size,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [XLEN-1:0]              wdata_in,
    input  logic [XLEN-1:0]              rdata_in,
    output logic [XLEN-1:0]              wdata_out,
    output logic [XLEN/8-1:0]            be_out,
    output logic [XLEN-1:0]              rdata_out
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    // Low offset bits below the access size are ignored, so misaligned accesses fall onto the aligned slot.
    localparam logic [OFF_W-1:0] H_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] W_MASK = ~OFF_W'(3);
    localparam logic [NB-1:0]    BE_B   = NB'(1);
    localparam logic [NB-1:0]    BE_H   = NB'(3);
    localparam logic [NB-1:0]    BE_W   = NB'(15);

    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    always_comb begin
        off_h     = offset & H_MASK;
        off_w     = offset & W_MASK;
        byte_v    = rdata_in[{offset, 3'b000} +: 8];
        half_v    = rdata_in[{off_h, 3'b000} +: 16];
        word_v    = rdata_in[{off_w, 3'b000} +: 32];
        wdata_out = {(NB/4){wdata_in[31:0]}};
        be_out    = BE_W << off_w;
        rdata_out = XLEN'($signed(word_v));
        case (size)
            SZ_B: begin
                wdata_out = {NB{wdata_in[7:0]}};
                be_out    = BE_B << offset;
                rdata_out = XLEN'($signed(byte_v));
            end
            SZ_BU: begin
                wdata_out = {NB{wdata_in[7:0]}};
                be_out    = BE_B << offset;
                rdata_out = XLEN'(byte_v);
            end
            SZ_H: begin
                wdata_out = {(NB/2){wdata_in[15:0]}};
                be_out    = BE_H << off_h;
                rdata_out = XLEN'($signed(half_v));
            end
            SZ_HU: begin
                wdata_out = {(NB/2){wdata_in[15:0]}};
                be_out    = BE_H << off_h;
                rdata_out = XLEN'(half_v);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage with a req/ack data port and the M->W register.
// Optional build macro MEM_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of issuing them.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RS_W   = 2,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteM,
    input  logic [RS_W-1:0]      ResultSrcM,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic [2:0]           MemSizeM,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [REG_AW-1:0]    RdM,
    output logic                 StallM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_be,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_ack,
    output logic                 RegWriteW,
    output logic [RS_W-1:0]      ResultSrcW,
    output logic [XLEN-1:0]      ALUResultW,
    output logic [XLEN-1:0]      ReadDataW,
    output logic [REG_AW-1:0]    RdW,
    output logic                 MisalignW,
    output state_e               state_dbg
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    // Handshake: a transfer completes in any cycle where mem_req and mem_ack are both 1; once raised,
    // mem_req and its addr/we/wdata/be stay stable until that cycle. mem_ack with mem_req=0 is ignored.

    state_e              state_q, state_d;
    logic                reg_write_w_q, reg_write_w_d;
    logic [RS_W-1:0]     result_src_w_q, result_src_w_d;
    logic [XLEN-1:0]     alu_result_w_q, alu_result_w_d;
    logic [XLEN-1:0]     read_data_w_q, read_data_w_d;
    logic [REG_AW-1:0]   rd_w_q, rd_w_d;
    logic                misalign_w_q, misalign_w_d;

    logic [OFF_W-1:0]    offset;
    logic                access;
    logic                misalign_m;
    logic                go;
    logic [XLEN-1:0]     store_data;
    logic [NB-1:0]       store_be;
    logic [XLEN-1:0]     load_data;

    assign offset = ALUResultM[OFF_W-1:0];
    assign access = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign_m = 1'b0;
        if (access) begin
            case (MemSizeM)
                SZ_H, SZ_HU: misalign_m = offset[0];
                SZ_W:        misalign_m = (offset[1:0] != 2'b00);
                default:     misalign_m = 1'b0;
            endcase
        end
    end
`else
    assign misalign_m = 1'b0;
`endif

    assign go = access & ~misalign_m;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size      (MemSizeM),
        .offset    (offset),
        .wdata_in  (WriteDataM),
        .rdata_in  (mem_rdata),
        .wdata_out (store_data),
        .be_out    (store_be),
        .rdata_out (load_data)
    );

    assign mem_addr  = {ALUResultM[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_wdata = store_data;
    assign mem_be    = MemWriteM ? store_be : {NB{1'b1}};
    assign mem_we    = mem_req & MemWriteM;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        StallM  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        mem_req = 1'b1;
                        if (!mem_ack) begin
                            StallM  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_d = IDLE;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        reg_write_w_d  = RegWriteM & ~misalign_m;
        result_src_w_d = ResultSrcM;
        alu_result_w_d = ALUResultM;
        read_data_w_d  = (MemReadM & ~misalign_m) ? load_data : '0;
        rd_w_d         = RdM;
        misalign_w_d   = misalign_m;
        // A stalled cycle hands writeback a bubble; only the enables matter.
        if (StallM) begin
            reg_write_w_d = 1'b0;
            misalign_w_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
            rd_w_q         <= '0;
            misalign_w_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            rd_w_q         <= rd_w_d;
            misalign_w_q   <= misalign_w_d;
        end
    end

    assign RegWriteW  = reg_write_w_q;
    assign ResultSrcW = result_src_w_q;
    assign ALUResultW = alu_result_w_q;
    assign ReadDataW  = read_data_w_q;
    assign RdW        = rd_w_q;
    assign MisalignW  = misalign_w_q;
    assign state_dbg  = state_q;

endmodule
